// File: rtl/onehot_led_ctrl.sv
// Registered binary-to-one-hot LED driver with enable-gated prescaler and
// DECODE / SCAN / BLINK / BOUNCE display modes; all outputs registered.
module onehot_led_ctrl #(
    parameter int IN_W  = 3,
    parameter int DIV_W = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [1:0]           mode_i,
    input  logic [IN_W-1:0]      binary_in,
    input  logic                 load_i,
    input  logic                 dir_i,
    input  logic [DIV_W-1:0]     div_i,
    output logic [(2**IN_W)-1:0] decoder_out,
    output logic [IN_W-1:0]      index_o,
    output logic                 tick_o
);

    localparam int OUT_W = 2**IN_W;
    localparam logic [IN_W-1:0] IDX_MAX = {IN_W{1'b1}};

    typedef enum logic [1:0] {
        M_DECODE = 2'b00,
        M_SCAN   = 2'b01,
        M_BLINK  = 2'b10,
        M_BOUNCE = 2'b11
    } mode_e;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  idx_q, idx_d;
    logic             ph_q, ph_d;
    logic             bdir_q, bdir_d;
    mode_e            mode_q, mode_in;
    logic [OUT_W-1:0] dec_q, dec_d;
    logic             tick_q, tick_d;

    assign mode_in = mode_e'(mode_i);

    function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] v);
        return OUT_W'(1) << v;
    endfunction

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        ph_d   = ph_q;
        bdir_d = bdir_q;
        tick_d = 1'b0;
        // Priority: load, then mode change, then prescaler terminal count.
        if (load_i) begin
            idx_d = binary_in;
            cnt_d = '0;
            ph_d  = 1'b1;
        end else if (mode_in != mode_q) begin
            cnt_d = '0;
            ph_d  = 1'b1;
        end else if (cnt_q == div_i) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            case (mode_in)
                M_SCAN:  idx_d = dir_i ? idx_q - IN_W'(1) : idx_q + IN_W'(1);
                M_BLINK: ph_d = ~ph_q;
                M_BOUNCE: begin
                    if (!bdir_q) begin
                        if (idx_q == IDX_MAX) begin
                            bdir_d = 1'b1;
                            idx_d  = idx_q - IN_W'(1);
                        end else begin
                            idx_d  = idx_q + IN_W'(1);
                        end
                    end else begin
                        if (idx_q == '0) begin
                            bdir_d = 1'b0;
                            idx_d  = IN_W'(1);
                        end else begin
                            idx_d  = idx_q - IN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        case (mode_in)
            M_DECODE: dec_d = onehot(binary_in);
            M_BLINK:  dec_d = ph_d ? onehot(binary_in) : '0;
            default:  dec_d = onehot(idx_d);
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            ph_q   <= 1'b1;
            bdir_q <= 1'b0;
            mode_q <= M_DECODE;
            dec_q  <= '0;
            tick_q <= 1'b0;
        end else if (!en_i) begin
            dec_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            ph_q   <= ph_d;
            bdir_q <= bdir_d;
            mode_q <= mode_in;
            dec_q  <= dec_d;
            tick_q <= tick_d;
        end
    end

    assign decoder_out = dec_q;
    assign index_o     = idx_q;
    assign tick_o      = tick_q;

endmodule

// File: tb/tb_onehot_led_ctrl.sv
// Directed bench for onehot_led_ctrl at IN_W=3 (main), IN_W=1 and IN_W=4.
module tb_onehot_led_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // IN_W = 3
    logic        rst_a, en_a, load_a, dir_a, tick_a;
    logic [1:0]  mode_a;
    logic [2:0]  bin_a, idx_a;
    logic [23:0] div_a;
    logic [7:0]  dec_a;
    // IN_W = 1
    logic        rst_b, en_b, load_b, dir_b, tick_b;
    logic [1:0]  mode_b;
    logic [0:0]  bin_b, idx_b;
    logic [23:0] div_b;
    logic [1:0]  dec_b;
    // IN_W = 4
    logic        rst_c, en_c, load_c, dir_c, tick_c;
    logic [1:0]  mode_c;
    logic [3:0]  bin_c, idx_c;
    logic [23:0] div_c;
    logic [15:0] dec_c;

    onehot_led_ctrl #(.IN_W(3), .DIV_W(24)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .en_i(en_a), .mode_i(mode_a), .binary_in(bin_a),
        .load_i(load_a), .dir_i(dir_a), .div_i(div_a), .decoder_out(dec_a),
        .index_o(idx_a), .tick_o(tick_a));

    onehot_led_ctrl #(.IN_W(1), .DIV_W(24)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .en_i(en_b), .mode_i(mode_b), .binary_in(bin_b),
        .load_i(load_b), .dir_i(dir_b), .div_i(div_b), .decoder_out(dec_b),
        .index_o(idx_b), .tick_o(tick_b));

    onehot_led_ctrl #(.IN_W(4), .DIV_W(24)) dut_c (
        .clk_i(clk), .rst_i(rst_c), .en_i(en_c), .mode_i(mode_c), .binary_in(bin_c),
        .load_i(load_c), .dir_i(dir_c), .div_i(div_c), .decoder_out(dec_c),
        .index_o(idx_c), .tick_o(tick_c));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b0; load_a = 1'b0; dir_a = 1'b0; mode_a = 2'b00; bin_a = '0; div_a = '0;
        rst_b = 1'b1; en_b = 1'b0; load_b = 1'b0; dir_b = 1'b0; mode_b = 2'b00; bin_b = '0; div_b = '0;
        rst_c = 1'b1; en_c = 1'b0; load_c = 1'b0; dir_c = 1'b0; mode_c = 2'b00; bin_c = '0; div_c = '0;
        cyc();
        cyc();
        checks++;
        if (dec_a !== 8'h00 || idx_a !== 3'd0 || tick_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_a dec=%h idx=%0d tick=%b exp dec=00 idx=0 tick=0", dec_a, idx_a, tick_a);
        end
        checks++;
        if (dec_b !== 2'b00 || dec_c !== 16'h0000 || idx_b !== 1'b0 || idx_c !== 4'd0) begin
            failures++;
            $display("FAIL reset_bc dec_b=%h dec_c=%h idx_b=%0d idx_c=%0d exp all 0", dec_b, dec_c, idx_b, idx_c);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    endtask

    task automatic test_decode();
        logic [7:0] exp_dec [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        en_a = 1'b1; mode_a = 2'b00; div_a = 24'd2; bin_a = 3'd5;
        cyc();
        checks++;
        if (dec_a !== 8'h20) begin
            failures++;
            $display("FAIL decode_5 dec=%h exp=20", dec_a);
        end
        for (int i = 0; i < 8; i++) begin
            bin_a = 3'(i);
            cyc();
            checks++;
            if (dec_a !== exp_dec[i]) begin
                failures++;
                $display("FAIL decode_sweep in=%0d dec=%h exp=%h", i, dec_a, exp_dec[i]);
            end
        end
    endtask

    task automatic test_scan();
        logic [2:0] sidx [6] = '{3'd7, 3'd0, 3'd1, 3'd0, 3'd7, 3'd6};
        logic [7:0] sdec [6] = '{8'h80, 8'h01, 8'h02, 8'h01, 8'h80, 8'h40};
        logic [2:0] prev;
        div_a = 24'd2; mode_a = 2'b01; dir_a = 1'b0; bin_a = 3'd6; load_a = 1'b1;
        cyc();
        load_a = 1'b0;
        checks++;
        if (idx_a !== 3'd6 || dec_a !== 8'h40 || tick_a !== 1'b0) begin
            failures++;
            $display("FAIL scan_load idx=%0d dec=%h tick=%b exp idx=6 dec=40 tick=0", idx_a, dec_a, tick_a);
        end
        prev = 3'd6;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) dir_a = 1'b1;
            for (int c = 1; c <= 3; c++) begin
                cyc();
                checks++;
                if (c < 3) begin
                    if (idx_a !== prev || tick_a !== 1'b0) begin
                        failures++;
                        $display("FAIL scan_hold step=%0d idx=%0d tick=%b exp idx=%0d tick=0", k, idx_a, tick_a, prev);
                    end
                end else begin
                    if (idx_a !== sidx[k] || dec_a !== sdec[k] || tick_a !== 1'b1) begin
                        failures++;
                        $display("FAIL scan_step step=%0d idx=%0d dec=%h tick=%b exp idx=%0d dec=%h tick=1",
                                 k, idx_a, dec_a, tick_a, sidx[k], sdec[k]);
                    end
                end
            end
            prev = sidx[k];
        end
    endtask

    task automatic test_bounce();
        logic [2:0] bidx [16] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
                                  3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
        logic [7:0] bdec [16] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                  8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
        div_a = 24'd0; mode_a = 2'b11; dir_a = 1'b0; bin_a = 3'd6; load_a = 1'b1;
        cyc();
        load_a = 1'b0;
        checks++;
        if (idx_a !== 3'd6 || dec_a !== 8'h40) begin
            failures++;
            $display("FAIL bounce_load idx=%0d dec=%h exp idx=6 dec=40", idx_a, dec_a);
        end
        for (int k = 0; k < 16; k++) begin
            cyc();
            checks++;
            if (idx_a !== bidx[k] || dec_a !== bdec[k] || tick_a !== 1'b1) begin
                failures++;
                $display("FAIL bounce_step step=%0d idx=%0d dec=%h tick=%b exp idx=%0d dec=%h tick=1",
                         k, idx_a, dec_a, tick_a, bidx[k], bdec[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Entered bouncing downward at idx 6.
        rst_a = 1'b1;
        cyc();
        checks++;
        if (idx_a !== 3'd0 || dec_a !== 8'h00 || tick_a !== 1'b0) begin
            failures++;
            $display("FAIL midreset idx=%0d dec=%h tick=%b exp idx=0 dec=00 tick=0", idx_a, dec_a, tick_a);
        end
        rst_a = 1'b0; bin_a = 3'd4; load_a = 1'b1;
        cyc();
        load_a = 1'b0;
        checks++;
        if (idx_a !== 3'd4 || dec_a !== 8'h10) begin
            failures++;
            $display("FAIL midreset_load idx=%0d dec=%h exp idx=4 dec=10", idx_a, dec_a);
        end
        cyc();
        checks++;
        if (idx_a !== 3'd5 || dec_a !== 8'h20) begin
            failures++;
            $display("FAIL midreset_bdir idx=%0d dec=%h exp idx=5 dec=20", idx_a, dec_a);
        end
    endtask

    task automatic test_blink();
        logic [7:0] edec [16] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h04, 8'h04,
                                  8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
        div_a = 24'd3; bin_a = 3'd2;
        for (int e = 0; e < 16; e++) begin
            mode_a = (e == 6) ? 2'b00 : 2'b10;
            cyc();
            checks++;
            if (dec_a !== edec[e]) begin
                failures++;
                $display("FAIL blink edge=%0d dec=%h exp=%h", e + 1, dec_a, edec[e]);
            end
        end
    endtask

    task automatic test_simultaneous();
        mode_a = 2'b01; div_a = 24'd2; dir_a = 1'b0; bin_a = 3'd0; load_a = 1'b1;
        cyc();
        load_a = 1'b0;
        cyc();
        cyc();
        bin_a = 3'd3; load_a = 1'b1;
        cyc();
        load_a = 1'b0;
        checks++;
        if (idx_a !== 3'd3 || dec_a !== 8'h08 || tick_a !== 1'b0) begin
            failures++;
            $display("FAIL simul_load idx=%0d dec=%h tick=%b exp idx=3 dec=08 tick=0", idx_a, dec_a, tick_a);
        end
        cyc();
        cyc();
        checks++;
        if (idx_a !== 3'd3 || tick_a !== 1'b0) begin
            failures++;
            $display("FAIL simul_hold idx=%0d tick=%b exp idx=3 tick=0", idx_a, tick_a);
        end
        cyc();
        checks++;
        if (idx_a !== 3'd4 || dec_a !== 8'h10 || tick_a !== 1'b1) begin
            failures++;
            $display("FAIL simul_tick idx=%0d dec=%h tick=%b exp idx=4 dec=10 tick=1", idx_a, dec_a, tick_a);
        end
        cyc();
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_a = (i == 2);
            bin_a  = 3'd7;
            cyc();
            checks++;
            if (dec_a !== 8'h00 || tick_a !== 1'b0 || idx_a !== 3'd4) begin
                failures++;
                $display("FAIL en_off cyc=%0d dec=%h tick=%b idx=%0d exp dec=00 tick=0 idx=4", i, dec_a, tick_a, idx_a);
            end
        end
        load_a = 1'b0; en_a = 1'b1;
        cyc();
        checks++;
        if (dec_a !== 8'h10 || tick_a !== 1'b0 || idx_a !== 3'd4) begin
            failures++;
            $display("FAIL en_on dec=%h tick=%b idx=%0d exp dec=10 tick=0 idx=4", dec_a, tick_a, idx_a);
        end
        cyc();
        checks++;
        if (dec_a !== 8'h20 || tick_a !== 1'b1 || idx_a !== 3'd5) begin
            failures++;
            $display("FAIL en_resume dec=%h tick=%b idx=%0d exp dec=20 tick=1 idx=5", dec_a, tick_a, idx_a);
        end
    endtask

    task automatic test_widths();
        logic [0:0] eb_idx [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] eb_dec [5] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
        en_a = 1'b0;
        en_b = 1'b1; mode_b = 2'b11; div_b = 24'd0; bin_b = 1'b0; load_b = 1'b1;
        cyc();
        load_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin
                rst_b = 1'b1;
                cyc();
                rst_b = 1'b0;
                checks++;
                if (idx_b !== 1'b0 || dec_b !== 2'b00) begin
                    failures++;
                    $display("FAIL w1_reset idx=%0d dec=%b exp idx=0 dec=00", idx_b, dec_b);
                end
            end
            if (k > 0) cyc();
            checks++;
            if (idx_b !== eb_idx[k] || dec_b !== eb_dec[k]) begin
                failures++;
                $display("FAIL w1_bounce step=%0d idx=%0d dec=%b exp idx=%0d dec=%b", k, idx_b, dec_b, eb_idx[k], eb_dec[k]);
            end
        end
        en_b = 1'b0;

        en_c = 1'b1; mode_c = 2'b11; div_c = 24'd0; bin_c = 4'd14; load_c = 1'b1;
        cyc();
        load_c = 1'b0;
        checks++;
        if (idx_c !== 4'd14 || dec_c !== 16'h4000) begin
            failures++;
            $display("FAIL w4_load idx=%0d dec=%h exp idx=14 dec=4000", idx_c, dec_c);
        end
        cyc();
        checks++;
        if (idx_c !== 4'd15 || dec_c !== 16'h8000) begin
            failures++;
            $display("FAIL w4_top idx=%0d dec=%h exp idx=15 dec=8000", idx_c, dec_c);
        end
        cyc();
        checks++;
        if (idx_c !== 4'd14 || dec_c !== 16'h4000) begin
            failures++;
            $display("FAIL w4_turn idx=%0d dec=%h exp idx=14 dec=4000", idx_c, dec_c);
        end
        rst_c = 1'b1;
        cyc();
        rst_c = 1'b0;
        checks++;
        if (idx_c !== 4'd0 || dec_c !== 16'h0000 || tick_c !== 1'b0) begin
            failures++;
            $display("FAIL w4_reset idx=%0d dec=%h tick=%b exp idx=0 dec=0000 tick=0", idx_c, dec_c, tick_c);
        end
        bin_c = 4'd7; load_c = 1'b1;
        cyc();
        load_c = 1'b0;
        cyc();
        checks++;
        if (idx_c !== 4'd8 || dec_c !== 16'h0100) begin
            failures++;
            $display("FAIL w4_bdir idx=%0d dec=%h exp idx=8 dec=0100", idx_c, dec_c);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_scan();
        test_bounce();
        test_reset_mid();
        test_blink();
        test_simultaneous();
        test_widths();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onehot_led_ctrl.md
# onehot_led_ctrl

Parametrised, registered binary-to-one-hot LED driver, the next generation of the board's combinational 3-to-8 LED decoder. It adds selectable width, an enable-gated clock prescaler and four display modes: direct decode, walking scan, blink and bounce. It sits between the lab's control logic and the LED bank; `decoder_out` drives the LEDs directly (bit k high = LED k on).

## Interface
- `IN_W`, default 3: binary index width. Output width is `OUT_W = 2**IN_W`. Legal range is 1..6.
- `DIV_W`, default 24: prescaler width.
- `clk_i`, in, 1: single clock, rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `en_i`, in, 1: block enable. Low forces LEDs off and freezes all state.
- `mode_i`, in, 2: display mode. 00 DECODE, 01 SCAN, 10 BLINK, 11 BOUNCE.
- `binary_in`, in, IN_W: index for DECODE/BLINK, and load value for SCAN/BOUNCE.
- `load_i`, in, 1: one-cycle strobe that loads `binary_in` into the index.
- `dir_i`, in, 1: SCAN direction. 0 = up (index+1), 1 = down (index−1).
- `div_i`, in, DIV_W: prescaler terminal count. Tick period is `div_i+1` cycles.
- `decoder_out`, out, OUT_W: registered one-hot (or zero) LED vector.
- `index_o`, out, IN_W: current internal index register.
- `tick_o`, out, 1: registered one-cycle pulse, high in the cycle after a prescaler terminal count.

## Operation
- **State:** prescaler counter `cnt` (DIV_W), index `idx` (IN_W), blink phase `ph`, bounce direction `bdir` (0 = up), registered copy of `mode_i`.
- **Reset** (`rst_i`=1 at an edge; overrides everything including `en_i`):
  - `cnt`=0, `idx`=0, `ph`=1, `bdir`=0.
  - `decoder_out`=0, `index_o`=0, `tick_o`=0.
- **en_i=0:**
  - `cnt`, `idx`, `ph` and `bdir` hold.
  - `decoder_out`=0 and `tick_o`=0 from the next edge.
  - `load_i` is ignored.
- **Prescaler** (en_i=1):
  - If `cnt`==`div_i`, then `cnt`←0 and an internal tick fires.
  - Otherwise `cnt`←`cnt`+1.
  - If `div_i` drops below `cnt`, `cnt` continues counting and wraps modulo 2^DIV_W. This is legal, but the period is undefined until the wrap.
- **Mode change** (`mode_i` differs from its registered copy): `cnt`←0, `ph`←1, no tick that cycle. `idx` and `bdir` are kept.
- **load_i** (en_i=1):
  - `idx`←`binary_in`, `cnt`←0, `ph`←1.
  - Load beats a simultaneous tick or mode change; the tick is discarded.
- **On tick, per mode:**
  - DECODE: no state change.
  - SCAN: `idx`←`idx`±1 modulo OUT_W. So 7→0 going up and 0→7 going down when IN_W=3.
  - BLINK: `ph`←~`ph`.
  - BOUNCE, `bdir`=0:
    - If `idx`==OUT_W−1, then `bdir`←1 and `idx`←`idx`−1.
    - Otherwise `idx`←`idx`+1.
  - BOUNCE, `bdir`=1:
    - If `idx`==0, then `bdir`←0 and `idx`←1.
    - Otherwise `idx`←`idx`−1.
  - BOUNCE with IN_W=1: `idx` toggles 0↔1 every tick.
- **Output function** (en_i=1), computed from next-state values and registered:
  - DECODE: onehot(`binary_in`).
  - SCAN / BOUNCE: onehot(next `idx`).
  - BLINK: if next `ph`, onehot(`binary_in`); otherwise 0.
- **Invariant:** `decoder_out` has at most one bit set at all times.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- DECODE latency is 1 cycle: `binary_in` sampled at edge t appears on `decoder_out` after edge t.
- SCAN/BOUNCE: `decoder_out` and `index_o` change on the same edge as `idx`. `tick_o` is high for exactly one cycle coincident with that update.
- Period: with constant `div_i`=D and en_i=1, a tick occurs every D+1 cycles. In SCAN, each LED is lit for D+1 cycles.
- After `load_i` at edge t:
  - `index_o`=`binary_in` after edge t.
  - The first tick is D+1 edges later.
- en_i 1→0: outputs are 0 after the next edge.
- en_i 0→1: the prescaler resumes from its held `cnt`, and the output is restored after the next edge.
- Reset mid-scan takes effect at that edge. The next tick occurs D+1 cycles after reset is released.

## Test plan
- **Reset/DECODE:** IN_W=3. Assert `rst_i` for 2 cycles → all outputs 0. Then mode=00, en=1, `binary_in`=5 → `decoder_out`=8'h20 one cycle later. Sweep 0..7 → 01,02,04,…,80.
- **SCAN wrap + dir:** div=2, load 6, dir=0 → `index_o` 6,7,0,1 every 3 cycles, `tick_o` one-cycle pulses. Set dir=1 at index 1 → 0,7,6.
- **BOUNCE ends:** div=0, load 6 → idx 7,6,5,…,0,1,2 with `bdir` flipping at 7 and 0. Output is never two-hot.
- **BLINK:** div=3, `binary_in`=2 → `decoder_out` alternates 8'h04 / 8'h00 every 4 cycles. A mode change restarts in the ON phase.
- **Simultaneous events:** assert `load_i` (value 3) in the terminal-count cycle of SCAN → `index_o`=3 (not incremented), `tick_o`=0, next tick D+1 cycles later. Also assert en=0 mid-period for 5 cycles → outputs 0, `index_o` held, period resumes with the remaining count.
- **Reset mid-operation:** `rst_i` during BOUNCE with `bdir`=1 → idx=0 and `bdir`=0. Repeat the test with IN_W=1 and IN_W=4 (`decoder_out` 2 and 16 bits).
